// File: rtl/ascii_uart_pkg.sv
// Shared types and constants for the ASCII UART transmitter.
// Optional even-parity bit is enabled by defining ASCII_UART_TX_PARITY_EN.
package ascii_uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef ASCII_UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  localparam int unsigned DataBits   = 8;
  localparam logic        StartLevel = 1'b0;
  localparam logic        StopLevel  = 1'b1;

endpackage

// File: rtl/ascii_uart_fifo.sv
// Character buffer: power-of-two circular FIFO with registered fill count.
// full/empty derive only from the count register, never from push/pop.
module ascii_uart_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [Width-1:0]         wdata,
  input  logic                     pop,
  output logic [Width-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned PtrW   = $clog2(Depth);
  localparam int unsigned CountW = PtrW + 1;

  logic [Width-1:0]  mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0] count_q;
  logic              do_push, do_pop;

  assign full    = (count_q == CountW'(Depth));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CountW'(1);
        2'b01:   count_q <= count_q - CountW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/ascii_uart_tx.sv
// Buffered UART transmitter: 8N1 frames, or 8E1 when ASCII_UART_TX_PARITY_EN is defined.
// Back-to-back frames leave no idle gap; tx is driven from a register.
module ascii_uart_tx
  import ascii_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned CntW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] BaudLast = CntW'(CLKS_PER_BIT - 1);

  state_e                      state_q, state_d;
  logic [CntW-1:0]             baud_q, baud_d;
  logic [2:0]                  bit_q, bit_d;
  logic [7:0]                  shift_q, shift_d;
  logic                        tx_q, tx_d;
  logic                        baud_last;
  logic                        pop;
  logic [7:0]                  fifo_rdata;
  logic                        fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  ascii_uart_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid && in_ready),
    .wdata (in_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign in_ready  = !fifo_full;
  assign busy      = (state_q != StIdle) || (fifo_count != '0);
  assign tx        = tx_q;
  assign baud_last = (baud_q == BaudLast);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + CntW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        baud_d = '0;
        if (!fifo_empty) begin
          state_d = StStart;
          pop     = 1'b1;
          shift_d = fifo_rdata;
        end
      end
      StStart: begin
        if (baud_last) begin
          state_d = StData;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      StData: begin
        if (baud_last) begin
          baud_d = '0;
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'(DataBits - 1)) begin
`ifdef ASCII_UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef ASCII_UART_TX_PARITY_EN
      StParity: begin
        if (baud_last) begin
          state_d = StStop;
          baud_d  = '0;
        end
      end
`endif
      StStop: begin
        if (baud_last) begin
          baud_d = '0;
          // Chain straight into the next start bit when more data is waiting.
          if (!fifo_empty) begin
            state_d = StStart;
            pop     = 1'b1;
            shift_d = fifo_rdata;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
        baud_d  = '0;
      end
    endcase
  end

  // Line level follows the state being entered so tx changes on the same edge as the state.
  always_comb begin
    tx_d = StopLevel;
    case (state_d)
      StStart:  tx_d = StartLevel;
      StData:   tx_d = shift_d[bit_d];
`ifdef ASCII_UART_TX_PARITY_EN
      StParity: tx_d = ^shift_d;
`endif
      default:  tx_d = StopLevel;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= StopLevel;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule
